arbitro_mux_2x4_rr: RTL
=======================

Name: arbitro_mux_2x4_rr

Overview:
Round-robin arbiter that shares one dual-channel 4-bit 2:1 multiplexer (select S, active-low enable E) between two requesters, A and B.
- Registers the grant and drives S/E.
- Gates the selected 4-bit word onto Y with a valid flag.
- Caps each requester's tenure at a programmable burst length so neither can starve the other.
- Sits between two producer blocks and the shared 4-bit output bus.

Parameters:
ANCHO, 4, data width of each channel and of Y (the shared mux is 4 bits wide; other values are for reuse only).
MAX_RAFAGA, 4, maximum consecutive granted cycles per tenure; legal 1..15; burst counter is 4 bits.

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  synchronous, active-high reset
req_a  input  1  requester A wants the bus; level, sampled every clk edge
req_b  input  1  requester B wants the bus
A  input  ANCHO  data word from requester A
B  input  ANCHO  data word from requester B
S  output  1  mux select, registered; 0 = A, 1 = B
E  output  1  mux enable, registered, active-low; 1 = outputs forced to 0
gnt_a  output  1  A owns the bus this cycle, registered
gnt_b  output  1  B owns the bus this cycle, registered
Y  output  ANCHO  shared bus: E ? 0 : (S ? B : A), combinational from registered S/E and live A/B
Y_valid  output  1  equals ~E

Behaviour:
- Clock, reset and sampling: one clock (clk); reset is synchronous and active-high.
- Reset values on the first clk edge with reset=1:
  - state = IDLE, S = 0, E = 1, gnt_a = 0, gnt_b = 0, cnt = 0.
  - ultimo (last-served pointer) = B, so A wins the first tie.
  - Y = 0 and Y_valid = 0 follow from E = 1.
  - Reset mid-tenure aborts the grant on that edge; no extra cycle.
- States: IDLE, SRV_A, SRV_B.
- Outputs decoded from registered state:
  - S = (state == SRV_B).
  - E = (state == IDLE).
  - gnt_a = (state == SRV_A); gnt_b = (state == SRV_B).
  - gnt_a and gnt_b are never both 1.
- Latency:
  - A request seen at edge n is granted from edge n+1.
  - Y reflects A/B in the same cycle as the grant (zero data latency).
- IDLE transitions:
  - Only req_a -> SRV_A; only req_b -> SRV_B.
  - Both -> the requester not equal to ultimo.
  - Neither -> stay in IDLE.
  - Entering any SRV state sets cnt = 0 and updates ultimo.
- SRV_A transitions, evaluated each edge (SRV_B is symmetric):
  - req_a = 0: go to SRV_B if req_b, else IDLE; cnt = 0.
  - req_a = 1 and cnt == MAX_RAFAGA-1: go to SRV_B if req_b, else stay in SRV_A with cnt = 0 (new tenure).
  - Otherwise: stay in SRV_A, cnt = cnt + 1.
- Handover: A->B happens directly with no IDLE bubble. E stays 0 and S toggles on the same edge.
- MAX_RAFAGA = 1: strict alternation while both request; cnt never leaves 0.
- Requester contract: a requester keeps req high while it wants data and must drive a valid word during every cycle its gnt is high.
- Dropping req ends the tenure at the next edge. The word in the cycle req drops is still on Y because gnt is still high.
- No combinational path from req_* to any output. Y depends combinationally only on A, B and registers.

Test Plan:
1. Reset held 2 cycles, then released with req_a = req_b = 0 -> S=0, E=1, gnt_a=gnt_b=0, Y=0000, Y_valid=0 on every cycle.
2. req_a rises at edge 3 with A=1010, req_b=0, and is held 10 cycles (MAX_RAFAGA=4) -> gnt_a=1 from edge 4; S=0, E=0, Y=1010 continuously; counter wraps every 4 cycles with no deassert gap.
3. req_a and req_b rise together out of reset (A=0011, B=1100) -> pattern repeats A,A,A,A,B,B,B,B, with S switching at each boundary and E=0 throughout. Y alternates 0011 and 1100 in 4-cycle blocks, and gnt_a and gnt_b are never both 1.
4. B being served (cnt=1), req_b drops while req_a=0 -> next edge IDLE, E=1, Y=0000. req_a rising 1 cycle later is granted 1 edge after that, and ultimo=B so A wins a tie.
5. MAX_RAFAGA=1 instance with both requesters held high -> gnt alternates A, B, A, B every cycle; Y follows A, B words cycle by cycle.
6. reset pulsed for 1 cycle in the middle of an A tenure -> on that edge E=1, gnt_a=0, Y=0000. With both still requesting, A is granted again on the edge after reset falls.

Source files
------------

// File: rtl/arbitro_mux_2x4_rr.sv
// Round-robin arbiter that shares one 2:1 mux between requesters A and B.
// It registers the grant and drives S/E, and it caps each tenure at MAX_RAFAGA cycles.
module arbitro_mux_2x4_rr #(
  parameter int ANCHO      = 4,
  parameter int MAX_RAFAGA = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [ANCHO-1:0] A,
  input  logic [ANCHO-1:0] B,
  output logic             S,
  output logic             E,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [ANCHO-1:0] Y,
  output logic             Y_valid
);

  typedef enum logic [1:0] {IDLE, SRV_A, SRV_B} stateT;

  localparam logic [3:0] CNT_LAST = 4'(MAX_RAFAGA - 1);

  stateT      stateReg, stateNext;
  logic [3:0] cntReg, cntNext;
  logic       ultimoReg, ultimoNext;  // last served: 0 = A, 1 = B

  always_comb begin
    stateNext = stateReg;
    cntNext   = 4'd0;
    case (stateReg)
      IDLE: begin
        if (req_a && req_b)  stateNext = ultimoReg ? SRV_A : SRV_B;
        else if (req_a)      stateNext = SRV_A;
        else if (req_b)      stateNext = SRV_B;
        else                 stateNext = IDLE;
      end
      SRV_A: begin
        if (!req_a)                 stateNext = req_b ? SRV_B : IDLE;
        else if (cntReg == CNT_LAST) stateNext = req_b ? SRV_B : SRV_A;
        else begin
          stateNext = SRV_A;
          cntNext   = cntReg + 4'd1;
        end
      end
      SRV_B: begin
        if (!req_b)                 stateNext = req_a ? SRV_A : IDLE;
        else if (cntReg == CNT_LAST) stateNext = req_a ? SRV_A : SRV_B;
        else begin
          stateNext = SRV_B;
          cntNext   = cntReg + 4'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    ultimoNext = ultimoReg;
    if (stateNext == SRV_A)      ultimoNext = 1'b0;
    else if (stateNext == SRV_B) ultimoNext = 1'b1;
  end

  // Mux controls are registered from the next state, so no req_* path reaches an output.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg  <= IDLE;
      cntReg    <= 4'd0;
      ultimoReg <= 1'b1;
      S         <= 1'b0;
      E         <= 1'b1;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      cntReg    <= cntNext;
      ultimoReg <= ultimoNext;
      S         <= (stateNext == SRV_B);
      E         <= (stateNext == IDLE);
      gnt_a     <= (stateNext == SRV_A);
      gnt_b     <= (stateNext == SRV_B);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ANCHO; gi++) begin : genY
      assign Y[gi] = ~E & (S ? B[gi] : A[gi]);
    end
  endgenerate

  assign Y_valid = ~E;

endmodule
